// File: rtl/ah_lru_grant_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ah_lru_seq_pkg: shared types and defaults for the LRU grant sequencer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ah_lru_seq_pkg;

    localparam int DEFAULT_NUM_REQ  = 8;
    localparam int DEFAULT_MAX_HOLD = 64;
    localparam int RANK_MAX_W       = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [RANK_MAX_W-1:0] rank_t;

    // Requester 0 starts as the least recently granted (highest rank).
    function automatic rank_t reset_rank(input int num_req, input int idx);
        return rank_t'(num_req - 1 - idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ah_lru_grant_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ah_lru_grant_sequencer_if: requester/grant bundle of the sequencer   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ah_lru_grant_sequencer_if #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic               res_busy;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic               timeout;

    modport master (
        output req, done, res_busy,
        input  gnt, gnt_vld, gnt_idx, timeout
    );

    modport slave (
        input  req, done, res_busy,
        output gnt, gnt_vld, gnt_idx, timeout
    );
endinterface
`default_nettype wire

// File: rtl/ah_lru_grant_sequencer_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ah_lru_pick: combinational selector of the requester with max rank   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ah_lru_pick #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] ranks,
    output logic [IDX_W-1:0]         winner,
    output logic                     any_req
);

    logic [IDX_W-1:0] w_best;
    logic             w_found;

    // Ranks are a permutation, so the maximum among requesters is unique.
    always_comb begin
        winner  = '0;
        w_best  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (!w_found || (ranks[i*IDX_W +: IDX_W] > w_best))) begin
                w_found = 1'b1;
                w_best  = ranks[i*IDX_W +: IDX_W];
                winner  = IDX_W'(i);
            end
        end
    end

    assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/ah_lru_grant_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ah_lru_grant_sequencer: least-recently-granted exclusive grant with  |
// | hold/release handshake. Optional watchdog: AH_LRU_SEQ_TIMEOUT_EN     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ah_lru_grant_sequencer
    import ah_lru_seq_pkg::*;
#(
    parameter int NUM_REQ  = DEFAULT_NUM_REQ,
    parameter int IDX_W    = $clog2(NUM_REQ),
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst,
    ah_lru_grant_sequencer_if.slave  bus
);

    generate
        if ((NUM_REQ < 2) || (NUM_REQ > 16) || (MAX_HOLD < 2)) begin : g_param_check
            $error("ah_lru_grant_sequencer: NUM_REQ must be 2..16 and MAX_HOLD >= 2");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [IDX_W-1:0]     w_gnt_idx_nxt;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
    logic [IDX_W-1:0]     r_rank     [NUM_REQ];
    logic [IDX_W-1:0]     w_rank_nxt [NUM_REQ];
    logic [NUM_REQ*IDX_W-1:0] w_ranks_packed;
    logic [IDX_W-1:0]     w_winner;
    logic                 w_any_req;
    logic                 w_grant;
    logic                 w_release;
    logic                 w_force;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
            assign w_ranks_packed[gi*IDX_W +: IDX_W] = r_rank[gi];
        end
    endgenerate

    ah_lru_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ranks   (w_ranks_packed),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    assign w_grant   = (r_state == IDLE) && w_any_req && !bus.res_busy;
    assign w_release = (r_state == HOLD) &&
                       (bus.done[r_gnt_idx] || !bus.req[r_gnt_idx]);

`ifdef AH_LRU_SEQ_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] r_hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (w_grant) begin
            r_hold_cnt <= '0;
        end else if (r_state == HOLD) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // A genuine release in the same cycle wins over the watchdog.
    assign w_force = (r_state == HOLD) && !w_release &&
                     (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_timeout_nxt = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rank_nxt[i] = r_rank[i];
        end

        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt   = HOLD;
                    w_gnt_nxt     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
                    w_gnt_idx_nxt = w_winner;
                    // Winner becomes most recent; everyone younger ages by one.
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (IDX_W'(j) == w_winner) begin
                            w_rank_nxt[j] = '0;
                        end else if (r_rank[j] < r_rank[w_winner]) begin
                            w_rank_nxt[j] = r_rank[j] + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end else if (w_force) begin
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_timeout <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rank[i] <= IDX_W'(reset_rank(NUM_REQ, i));
            end
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_timeout <= w_timeout_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rank[i] <= w_rank_nxt[i];
            end
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_vld = |r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ah_lru_grant_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ah_lru_grant_sequencer: scoreboard bench with timestamp LRU model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ah_lru_grant_sequencer;

    localparam int N  = 8;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ah_lru_grant_sequencer_if #(.NUM_REQ(N)) bus();

    ah_lru_grant_sequencer #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0] gnt;
        logic         vld;
        logic [2:0]   idx;
        logic         to;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference: each requester remembers when it was last granted;
    // the oldest requesting timestamp wins.
    int stamp [N];
    int now;
    bit m_hold;
    int m_owner;
    int m_held;
    bit m_to;

    function void model_reset();
        for (int i = 0; i < N; i++) stamp[i] = i - N;
        m_hold  = 0;
        m_owner = 0;
        m_held  = 0;
        m_to    = 0;
    endfunction

    function void model_step(input logic [N-1:0] r, input logic [N-1:0] d,
                             input logic b, input logic rs);
        int best;
        now++;
        if (rs) begin
            model_reset();
            return;
        end
        m_to = 0;
        if (!m_hold) begin
            if (r != '0 && !b) begin
                best = -1;
                for (int i = 0; i < N; i++)
                    if (r[i] && (best < 0 || stamp[i] < stamp[best])) best = i;
                stamp[best] = now;
                m_owner = best;
                m_hold  = 1;
                m_held  = 0;
            end
        end else if (d[m_owner] || !r[m_owner]) begin
            m_hold = 0;
        end else begin
`ifdef AH_LRU_SEQ_TIMEOUT_EN
            if (m_held == MH - 1) begin
                m_hold = 0;
                m_to   = 1;
            end else begin
                m_held++;
            end
`else
            m_held++;
`endif
        end
    endfunction

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d,
                       input logic b, input logic rs);
        exp_t e;
        @(negedge clk);
        rst          = rs;
        bus.req      = r;
        bus.done     = d;
        bus.res_busy = b;
        model_step(r, d, b, rs);
        e.gnt = m_hold ? (N'(1) << m_owner) : '0;
        e.vld = m_hold;
        e.idx = 3'(m_owner);
        e.to  = m_to;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.gnt !== e.gnt || bus.gnt_vld !== e.vld ||
                    bus.gnt_idx !== e.idx || bus.timeout !== e.to) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got gnt=%h vld=%b idx=%0d to=%b, expected gnt=%h vld=%b idx=%0d to=%b",
                             $time, bus.gnt, bus.gnt_vld, bus.gnt_idx, bus.timeout,
                             e.gnt, e.vld, e.idx, e.to);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] cur_req;
        logic [N-1:0] d;
        int           own;
        bit           was_hold;

        bus.req = '0;
        bus.done = '0;
        bus.res_busy = 1'b0;
        now = 0;
        model_reset();

        // Round robin under full load: owners 0..7 then 0 again
        cyc('0, '0, 0, 1);
        cyc('0, '0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            cyc(8'hFF, '0, 0, 0);
            cyc(8'hFF, N'(1) << m_owner, 0, 0);
        end

        // Grant 5 then release; req0 must beat 5
        cyc('0, '0, 0, 1);
        cyc(8'h20, '0, 0, 0);
        cyc(8'h20, 8'h20, 0, 0);
        cyc(8'h21, '0, 0, 0);
        cyc(8'h21, 8'h01, 0, 0);
        cyc(8'h20, '0, 0, 0);
        cyc(8'h20, 8'h20, 0, 0);

        // Busy window blocks new grants only
        for (int k = 0; k < 4; k++) cyc(8'h10, '0, 1, 0);
        cyc(8'h10, '0, 0, 0);
        cyc(8'h10, '0, 1, 0);
        cyc(8'h10, 8'h10, 1, 0);

        // Owner 3 aborts; it is then youngest and loses to 0
        cyc(8'h08, '0, 0, 0);
        cyc(8'h00, '0, 0, 0);
        cyc(8'h09, '0, 0, 0);
        cyc(8'h09, 8'h01, 0, 0);
        cyc(8'h08, '0, 0, 0);
        cyc(8'h08, 8'h08, 0, 0);

        // Reset during a grant to 2
        cyc('0, '0, 0, 1);
        cyc(8'h04, '0, 0, 0);
        cyc(8'h04, '0, 0, 1);
        cyc(8'hFF, '0, 0, 0);
        cyc(8'hFF, 8'h01, 0, 0);

        // Long hold without done (watchdog or indefinite hold)
        cyc(8'h02, '0, 0, 0);
        for (int k = 0; k < 100; k++) cyc(8'h02, 8'h01, 0, 0);
        cyc('0, '0, 0, 0);

        // Randomized traffic
        cur_req = '0;
        for (int k = 0; k < 2500; k++) begin
            was_hold = m_hold;
            own      = m_owner;
            for (int i = 0; i < N; i++) begin
                if (m_hold && i == m_owner) begin
                    if ($urandom_range(0, 19) == 0) cur_req[i] = 1'b0;
                end else if (!cur_req[i]) begin
                    cur_req[i] = ($urandom_range(0, 3) == 0);
                end
            end
            d = '0;
            if (m_hold && $urandom_range(0, 2) == 0) d[m_owner] = 1'b1;
            if ($urandom_range(0, 9) == 0) d[$urandom_range(0, N-1)] = 1'b1;
            cyc(cur_req, d, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0));
            if (was_hold && d[own] && $urandom_range(0, 1) == 0) cur_req[own] = 1'b0;
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
